// File: rtl/seg7_counter_display.sv
// Cascaded BCD up/down counter driving a time-multiplexed seven-segment display.
// Prescaler, counter, decoder and scanner share one clock; segments and selects are registered together.
module seg7_counter_display #(
    parameter int                DIGITS     = 4,
    parameter int                TICK_DIV   = 50_000_000,
    parameter int                SCAN_DIV   = 50_000,
    parameter int                ACTIVE_LOW = 1,
    parameter logic [DIGITS-1:0] DP_MASK    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  blank_lz,
    output logic [7:0]            out,
    output logic [DIGITS-1:0]     cntrl,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output logic                  led
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]     SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     DIG_MAX   = IW'(DIGITS - 1);
    localparam logic [7:0]        OUT_INV   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_INV   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h40;
        endcase
        return seg;
    endfunction

    function automatic logic [7:0] apply_polarity(input logic [7:0] segs);
        return segs ^ OUT_INV;
    endfunction

    logic [PW-1:0]       presc_p0;
    logic [SW-1:0]       scan_p0;
    logic [IW-1:0]       dig_p0;
    logic [3:0]          cnt_p0 [DIGITS];
    logic [3:0]          cnt_next [DIGITS];
    logic                roll;
    logic                carry;
    logic                tick;
    logic                step;
    logic [DIGITS-1:0]   lz;
    logic                zero_above;
    logic [3:0]          cur_digit;
    logic                cur_blank;
    logic                cur_dp;
    logic [DIGITS-1:0]   sel_next;
    logic [7:0]          seg_next;

    assign tick = (presc_p0 == PRESC_MAX);
    assign step = tick & en & ~clr;

    // Ripple the +1/-1 through the digits; carry out of the top digit is the rollover.
    always_comb begin
        cnt_next = cnt_p0;
        carry    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (up) begin
                    if (cnt_p0[k] >= 4'd9) begin
                        cnt_next[k] = 4'd0;
                    end else begin
                        cnt_next[k] = cnt_p0[k] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (cnt_p0[k] == 4'd0) begin
                        cnt_next[k] = 4'd9;
                    end else begin
                        cnt_next[k] = cnt_p0[k] - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        roll = carry;
    end

    // lz[k] is set when digit k and every digit above it are zero.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (cnt_p0[k] == 4'd0);
            lz[k]      = zero_above;
        end
    end

    always_comb begin
        cur_digit = cnt_p0[0];
        cur_blank = 1'b0;
        cur_dp    = DP_MASK[0];
        sel_next  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_p0 == IW'(k)) begin
                cur_digit   = cnt_p0[k];
                cur_blank   = (k != 0) && blank_lz && lz[k];
                cur_dp      = DP_MASK[k];
                sel_next[k] = 1'b1;
            end
        end
        seg_next = {cur_dp, cur_blank ? 7'h00 : seg7_decode(cur_digit)};
    end

    always_comb begin
        value = '0;
        for (int k = 0; k < DIGITS; k++) begin
            value[4*k +: 4] = cnt_p0[k];
        end
    end

    // Stage p0: prescaler, scanner and counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_p0 <= '0;
            scan_p0  <= '0;
            dig_p0   <= '0;
            wrap     <= 1'b0;
            led      <= 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                cnt_p0[k] <= 4'd0;
            end
        end else begin
            if (clr || presc_p0 == PRESC_MAX) begin
                presc_p0 <= '0;
            end else begin
                presc_p0 <= presc_p0 + PW'(1);
            end

            if (scan_p0 == SCAN_MAX) begin
                scan_p0 <= '0;
                dig_p0  <= (dig_p0 == DIG_MAX) ? '0 : dig_p0 + IW'(1);
            end else begin
                scan_p0 <= scan_p0 + SW'(1);
            end

            if (clr) begin
                for (int k = 0; k < DIGITS; k++) begin
                    cnt_p0[k] <= 4'd0;
                end
                wrap <= 1'b0;
            end else if (step) begin
                cnt_p0 <= cnt_next;
                wrap   <= roll;
            end else begin
                wrap <= 1'b0;
            end

            led <= led ^ step;
        end
    end

    // Stage p1: segments and select latched on the same edge to avoid ghosting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out   <= OUT_INV;
            cntrl <= SEL_INV;
        end else begin
            out   <= apply_polarity(seg_next);
            cntrl <= sel_next ^ SEL_INV;
        end
    end

endmodule
